// File: rtl/mem_stage_dcache_ctrl_if.sv
// Bundle between the EX/MEM requester, the data-cache controller and backing memory.
// slave = cache controller view, master = requester/memory side view.
interface mem_stage_dcache_ctrl_if;
  logic        req_valid;
  logic        we_cache;
  logic        is_word;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, we_cache, is_word, addr, wdata, mem_rdata, mem_ack,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, we_cache, is_word, addr, wdata, mem_rdata, mem_ack,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_stage_dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache (4-word lines) for the MEM stage.
// Misses are serviced word-serially over a req/ack port while stall holds the pipeline.
module mem_stage_dcache_ctrl #(
  parameter int INDEX_BITS = 3
) (
  input logic                      clk,
  input logic                      rst,
  mem_stage_dcache_ctrl_if.slave   io_dc
);
  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_k;
  logic [LINES-1:0]      r_valid, r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES][4];

  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_word, w_lane;
  logic [TAG_BITS-1:0]   w_tag;
  logic [31:0]           w_line_word, w_beat_word;
  logic                  w_hit, w_store_hit, w_ack, w_last_beat;
  logic                  w_stall, w_mem_req, w_mem_we;
  logic [31:0]           w_mem_addr, w_mem_wdata, w_rdata;

  assign w_index     = io_dc.addr[3+INDEX_BITS:4];
  assign w_word      = io_dc.addr[3:2];
  assign w_lane      = io_dc.addr[1:0];
  assign w_tag       = io_dc.addr[31:4+INDEX_BITS];
  assign w_line_word = r_data[w_index][w_word];
  assign w_beat_word = r_data[w_index][r_k];
  assign w_hit       = (r_state == S_IDLE) && io_dc.req_valid && r_valid[w_index]
                       && (r_tag[w_index] == w_tag);
  assign w_store_hit = w_hit && io_dc.we_cache;
  // mem_req is high exactly when not idle, so this drops acks that arrive unrequested
  assign w_ack       = io_dc.mem_ack && (r_state != S_IDLE);
  assign w_last_beat = w_ack && (r_k == 2'd3);

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_rdata     = '0;
    case (r_state)
      S_IDLE: begin
        if (io_dc.req_valid) begin
          if (w_hit) begin
            if (!io_dc.we_cache)
              w_rdata = io_dc.is_word ? w_line_word
                                      : {24'b0, w_line_word[{w_lane, 3'b000} +: 8]};
          end else begin
            w_stall = 1'b1;
            w_next  = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_REFILL;
          end
        end
      end
      S_WRITEBACK: begin
        w_stall     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {r_tag[w_index], w_index, r_k, 2'b00};
        w_mem_wdata = w_beat_word;
        if (w_last_beat) w_next = S_REFILL;
      end
      S_REFILL: begin
        w_stall    = 1'b1;
        w_mem_req  = 1'b1;
        w_mem_addr = {w_tag, w_index, r_k, 2'b00};
        if (w_last_beat) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign io_dc.stall     = w_stall;
  assign io_dc.mem_req   = w_mem_req;
  assign io_dc.mem_we    = w_mem_we;
  assign io_dc.mem_addr  = w_mem_addr;
  assign io_dc.mem_wdata = w_mem_wdata;
  assign io_dc.rdata     = w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_ack) r_k <= r_k + 2'd1;
      if (w_store_hit) r_dirty[w_index] <= 1'b1;
      if ((r_state == S_REFILL) && w_last_beat) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (w_store_hit) begin
      if (io_dc.is_word)
        r_data[w_index][w_word] <= io_dc.wdata;
      else
        r_data[w_index][w_word][{w_lane, 3'b000} +: 8] <= io_dc.wdata[7:0];
    end
    if ((r_state == S_REFILL) && w_ack) begin
      r_data[w_index][r_k] <= io_dc.mem_rdata;
      if (r_k == 2'd3) r_tag[w_index] <= w_tag;
    end
  end
endmodule
